// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, sequencer FSM states and default widths shared by the ALU sequencer slice
package alu_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_OPC_W = 4;

    localparam logic [DEF_OPC_W-1:0] OPC_NOP = 4'b0000;
    localparam logic [DEF_OPC_W-1:0] OPC_ADD = 4'b0001;
    localparam logic [DEF_OPC_W-1:0] OPC_SUB = 4'b0010;
    localparam logic [DEF_OPC_W-1:0] OPC_MUL = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        MUL_ISSUE,
        MUL_CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command, response and ALU drive bundle; rsp_ovf exists only when ALU_SEQ_OVF_EN is defined
interface alu_sequencer_if import alu_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPC_W = DEF_OPC_W
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPC_W-1:0] cmd_opcode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [OPC_W-1:0] alu_opcode;
    logic [WIDTH-1:0] alu_ain;
    logic [WIDTH-1:0] alu_bin;
    logic [WIDTH-1:0] alu_out;
`ifdef ALU_SEQ_OVF_EN
    logic             rsp_ovf;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready, alu_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_ovf, alu_opcode, alu_ain, alu_bin
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready, alu_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_ovf, alu_opcode, alu_ain, alu_bin
    );
`else
    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready, alu_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, alu_opcode, alu_ain, alu_bin
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready, alu_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, alu_opcode, alu_ain, alu_bin
    );
`endif

endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-level controller for the registered add/sub ALU; MUL runs as repeated ADDs; ALU_SEQ_OVF_EN adds rsp_ovf
module alu_sequencer import alu_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPC_W = DEF_OPC_W
) (
    input logic            clock,
    input logic            reset_n,
    alu_sequencer_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic [OPC_W-1:0] op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [OPC_W-1:0] alu_opcode;
    logic [WIDTH-1:0] alu_ain;
    logic [WIDTH-1:0] alu_bin;

    logic is_add;
    logic is_sub;
    logic is_mul;
    logic go_issue;
    logic go_mul;

    assign is_add   = bus.cmd_opcode == OPC_ADD;
    assign is_sub   = bus.cmd_opcode == OPC_SUB;
    assign is_mul   = bus.cmd_opcode == OPC_MUL;
    assign go_issue = is_add || is_sub;
    assign go_mul   = is_mul && (bus.cmd_b != '0);

`ifdef ALU_SEQ_OVF_EN
    logic             rsp_ovf;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   mul_sum;

    assign add_sum = {1'b0, a} + {1'b0, b};
    assign mul_sum = {1'b0, acc} + {1'b0, a};
    assign bus.rsp_ovf = rsp_ovf;
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and ALU drive; the ALU sees NOP (holds) outside the two issue states
    always_comb begin
        state_nxt  = state;
        alu_opcode = OPC_NOP;
        alu_ain    = '0;
        alu_bin    = '0;
        case (state)
            IDLE:
                if (bus.cmd_valid)
                    state_nxt = go_issue ? ISSUE : go_mul ? MUL_ISSUE : DONE;
            ISSUE: begin
                alu_opcode = op;
                alu_ain    = a;
                alu_bin    = b;
                state_nxt  = CAPTURE;
            end
            CAPTURE:
                state_nxt = DONE;
            MUL_ISSUE: begin
                alu_opcode = OPC_ADD;
                alu_ain    = acc;
                alu_bin    = a;
                state_nxt  = MUL_CAPTURE;
            end
            MUL_CAPTURE:
                state_nxt = (cnt == WIDTH'(1)) ? DONE : MUL_ISSUE;
            DONE:
                if (bus.rsp_ready)
                    state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    // Operand latches, MUL accumulator/step counter and held response registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op       <= OPC_NOP;
            a        <= '0;
            b        <= '0;
            acc      <= '0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            rsp_ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:
                    if (bus.cmd_valid) begin
                        op      <= bus.cmd_opcode;
                        a       <= bus.cmd_a;
                        b       <= bus.cmd_b;
                        acc     <= '0;
                        cnt     <= bus.cmd_b;
                        rsp_err <= !(go_issue || is_mul);
`ifdef ALU_SEQ_OVF_EN
                        rsp_ovf <= 1'b0;
`endif
                        if (!(go_issue || go_mul))
                            rsp_data <= '0;
                    end
                CAPTURE: begin
                    rsp_data <= bus.alu_out;
                    rsp_err  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
                    rsp_ovf  <= (op == OPC_SUB) ? (a < b) : add_sum[WIDTH];
`endif
                end
                MUL_CAPTURE: begin
                    acc <= bus.alu_out;
                    cnt <= cnt - WIDTH'(1);
`ifdef ALU_SEQ_OVF_EN
                    rsp_ovf <= rsp_ovf | mul_sum[WIDTH];
`endif
                    if (cnt == WIDTH'(1))
                        rsp_data <= bus.alu_out;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready  = state == IDLE;
    assign bus.rsp_valid  = state == DONE;
    assign bus.rsp_data   = rsp_data;
    assign bus.rsp_err    = rsp_err;
    assign bus.alu_opcode = alu_opcode;
    assign bus.alu_ain    = alu_ain;
    assign bus.alu_bin    = alu_bin;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed table-driven bench for alu_sequencer with a registered add/sub ALU model
module tb_alu_sequencer;
    import alu_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    alu_sequencer_if #(.WIDTH(4), .OPC_W(4)) bus ();

    alu_sequencer #(.WIDTH(4), .OPC_W(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Registered ALU: output updates one edge after an ADD/SUB issue, holds on NOP
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            bus.alu_out <= '0;
        else if (bus.alu_opcode == OPC_ADD)
            bus.alu_out <= bus.alu_ain + bus.alu_bin;
        else if (bus.alu_opcode == OPC_SUB)
            bus.alu_out <= bus.alu_ain - bus.alu_bin;
    end

    int tests   = 0;
    int fails   = 0;
    int bad_opc = 0;

    // The sequencer may only ever present NOP, ADD or SUB to the ALU
    always @(negedge clock)
        if (reset_n && bus.alu_opcode > OPC_SUB)
            bad_opc++;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] data;
        logic       err;
        int         lat;
        int         issues;
        logic       ovf;
    } vec_t;

    vec_t vecs[12];

    logic [3:0] ain_log[16];
    logic [3:0] bin_log[16];
    int         n_iss;
    int         lat;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present a command at a falling edge and hold it until the accepting rising edge
    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        @(negedge clock);
        bus.cmd_opcode = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_valid  = 1'b1;
        while (!bus.cmd_ready && n < 64) begin
            @(negedge clock);
            n++;
        end
        if (n >= 64) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no cmd_ready, expected one within 64 cycles");
        end
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until rsp_valid, logging every ALU issue on the way
    task automatic collect();
        lat   = 0;
        n_iss = 0;
        while (!bus.rsp_valid && lat < 64) begin
            if (bus.alu_opcode != OPC_NOP) begin
                if (n_iss < 16) begin
                    ain_log[n_iss] = bus.alu_ain;
                    bin_log[n_iss] = bus.alu_bin;
                end
                n_iss++;
            end
            @(posedge clock);
            #1;
            lat++;
        end
        if (lat >= 64) begin
            tests++;
            fails++;
            $display("FAIL rsp_timeout: got no rsp_valid, expected one within 64 cycles");
        end
    endtask

    initial begin
        // {op, a, b, data, err, edges after accept, ALU issues, ovf}
        // MUL b=0 and illegal opcodes go straight to DONE on the accepting edge itself
        vecs[0]  = '{4'h1, 4'd5,  4'd3, 4'd8,  1'b0, 2,  1, 1'b0};
        vecs[1]  = '{4'h2, 4'd3,  4'd5, 4'd14, 1'b0, 2,  1, 1'b1};
        vecs[2]  = '{4'h1, 4'd9,  4'd9, 4'd2,  1'b0, 2,  1, 1'b1};
        vecs[3]  = '{4'h3, 4'd3,  4'd4, 4'd12, 1'b0, 8,  4, 1'b0};
        vecs[4]  = '{4'h7, 4'd5,  4'd3, 4'd0,  1'b1, 0,  0, 1'b0};
        vecs[5]  = '{4'h2, 4'd9,  4'd4, 4'd5,  1'b0, 2,  1, 1'b0};
        vecs[6]  = '{4'h3, 4'd7,  4'd0, 4'd0,  1'b0, 0,  0, 1'b0};
        vecs[7]  = '{4'h3, 4'd5,  4'd5, 4'd9,  1'b0, 10, 5, 1'b1};
        vecs[8]  = '{4'h1, 4'd15, 4'd1, 4'd0,  1'b0, 2,  1, 1'b1};
        vecs[9]  = '{4'h3, 4'd15, 4'd1, 4'd15, 1'b0, 2,  1, 1'b0};
        vecs[10] = '{4'h0, 4'd6,  4'd2, 4'd0,  1'b1, 0,  0, 1'b0};
        vecs[11] = '{4'hF, 4'd1,  4'd1, 4'd0,  1'b1, 0,  0, 1'b0};

        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_a      = '0;
        bus.cmd_b      = '0;
        bus.rsp_ready  = 1'b1;

        #12;
        check("rst_cmd_ready",  bus.cmd_ready,  1);
        check("rst_rsp_valid",  bus.rsp_valid,  0);
        check("rst_rsp_data",   bus.rsp_data,   0);
        check("rst_rsp_err",    bus.rsp_err,    0);
        check("rst_alu_opcode", bus.alu_opcode, 0);
        check("rst_alu_ain",    bus.alu_ain,    0);
        check("rst_alu_bin",    bus.alu_bin,    0);
`ifdef ALU_SEQ_OVF_EN
        check("rst_rsp_ovf",    bus.rsp_ovf,    0);
`endif
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            collect();
            check($sformatf("v%0d_data", i),   bus.rsp_data, vecs[i].data);
            check($sformatf("v%0d_err", i),    bus.rsp_err,  vecs[i].err);
            check($sformatf("v%0d_lat", i),    lat,          vecs[i].lat);
            check($sformatf("v%0d_issues", i), n_iss,        vecs[i].issues);
`ifdef ALU_SEQ_OVF_EN
            check($sformatf("v%0d_ovf", i),    bus.rsp_ovf,  vecs[i].ovf);
`endif
            @(posedge clock);
            #1;
            check($sformatf("v%0d_ready_after", i), bus.cmd_ready, 1);
            check($sformatf("v%0d_valid_after", i), bus.rsp_valid, 0);
        end

        // MUL 3*4: four ADD steps accumulating 0,3,6,9 with bin fixed at 3
        send(4'h3, 4'd3, 4'd4);
        collect();
        check("mul_issues", n_iss, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mul_ain%0d", k), ain_log[k], 3 * k);
            check($sformatf("mul_bin%0d", k), bin_log[k], 3);
        end
        check("mul_data", bus.rsp_data, 12);
        check("mul_lat",  lat,          8);
        @(posedge clock);
        #1;

        // Backpressure: response held while a new command waits outside IDLE
        bus.rsp_ready = 1'b0;
        send(4'h1, 4'd2, 4'd3);
        collect();
        check("bp_data", bus.rsp_data, 5);
        @(negedge clock);
        bus.cmd_opcode = 4'h1;
        bus.cmd_a      = 4'd1;
        bus.cmd_b      = 4'd1;
        bus.cmd_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("bp_valid%0d", k), bus.rsp_valid,  1);
            check($sformatf("bp_data%0d", k),  bus.rsp_data,   5);
            check($sformatf("bp_ready%0d", k), bus.cmd_ready,  0);
            check($sformatf("bp_alu%0d", k),   bus.alu_opcode, 0);
        end
        @(negedge clock);
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_idle_ready", bus.cmd_ready, 1);
        check("bp_idle_valid", bus.rsp_valid, 0);
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        collect();
        check("bp_next_data", bus.rsp_data, 2);
        check("bp_next_lat",  lat,          2);
        @(posedge clock);
        #1;

        // Reset mid-MUL 5*6 during the fourth step, away from any clock edge
        send(4'h3, 4'd5, 4'd6);
        repeat (6) @(posedge clock);
        #1;
        check("mr_pre_opcode", bus.alu_opcode, 1);
        check("mr_pre_ain",    bus.alu_ain,    15);
        check("mr_pre_bin",    bus.alu_bin,    5);
        reset_n = 1'b0;
        #1;
        check("mr_cmd_ready",  bus.cmd_ready,  1);
        check("mr_rsp_valid",  bus.rsp_valid,  0);
        check("mr_rsp_data",   bus.rsp_data,   0);
        check("mr_rsp_err",    bus.rsp_err,    0);
        check("mr_alu_opcode", bus.alu_opcode, 0);
        check("mr_alu_ain",    bus.alu_ain,    0);
        check("mr_alu_bin",    bus.alu_bin,    0);
`ifdef ALU_SEQ_OVF_EN
        check("mr_rsp_ovf",    bus.rsp_ovf,    0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        send(4'h1, 4'd1, 4'd1);
        collect();
        check("mr_after_data", bus.rsp_data, 2);
        check("mr_after_lat",  lat,          2);
        @(posedge clock);
        #1;

        check("no_bad_alu_opcode", bad_opc, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
